// File: rtl/bw_clk_cclk_scan_seq_pkg.sv
// Shared types and helpers for the cclk scan-chain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bw_clk_scan_pkg;

  // Sequencer phases: waiting for a word, driving it onto the chain,
  // and waiting for the chain's tail bits to return.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  // The cycle counter must reach WIDTH+DLY-1 without wrapping.
  function automatic int cnt_width(input int width, input int dly);
    return $clog2(width + dly + 1);
  endfunction

endpackage

// File: rtl/bw_clk_cclk_scan_seq_if.sv
// Load/capture handshake plus serial chain pins of the scan sequencer.
// Latency: n/a (wiring only).
// Backpressure: load_vld must be held by the source until load_rdy.
interface bw_clk_cclk_scan_seq_if #(
  parameter int WIDTH = 16
);
  logic             load_vld;
  logic [WIDTH-1:0] load_data;
  logic             load_rdy;
  logic             sd;
  logic             scan_en;
  logic             so;
  logic             cap_vld;
  logic [WIDTH-1:0] cap_data;

  // Sequencer side.
  modport master (
    input  load_vld, load_data, so,
    output load_rdy, sd, scan_en, cap_vld, cap_data
  );

  // Word source / capture sink / chain side.
  modport slave (
    output load_vld, load_data, so,
    input  load_rdy, sd, scan_en, cap_vld, cap_data
  );
endinterface

// File: rtl/bw_clk_cclk_scan_seq_shreg.sv
// Parameterised right-shift register with parallel load and serial-in at the MSB.
// Latency: one cycle per load or shift.
// Backpressure: none; load has priority over shift_en.
module bw_clk_scan_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Parallel load wins; otherwise move one place toward bit 0, filling from sin.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/bw_clk_cclk_scan_seq.sv
// Shifts a parallel word LSB-first onto sd and captures the same number of bits from so after DLY cycles.
// Latency: accept to cap_vld is WIDTH+DLY+1 cycles; one word per WIDTH+DLY+1 cycles.
// Backpressure: load_rdy low outside IDLE; load_vld is ignored (not queued) while busy.
module bw_clk_cclk_scan_seq
  import bw_clk_scan_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DLY   = 1
) (
  input logic                   ck,
  input logic                   rst,
  bw_clk_cclk_scan_seq_if.master bus
);

  localparam int             CW         = cnt_width(WIDTH, DLY);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DLY);
  localparam logic [CW-1:0] LAST       = CW'(WIDTH + DLY - 1);

  scan_state_e      state_q;
  scan_state_e      state_d;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             shift_en;
  logic             cap_en;
  logic             cap_last;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] in_q;
  logic             unused_bits;

  // Next-state and per-cycle strobes; the counter alone decides phase lengths.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    cap_en   = 1'b0;
    cap_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_vld && bus.load_rdy) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cap_en   = (cnt_q >= CAP_FIRST);
        if (cnt_q == LAST_SHIFT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cap_en   = (cnt_q >= CAP_FIRST);
        cap_last = (cnt_q == LAST);
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycles since SHIFT entry; holds at the final drain count rather than wrapping.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q != IDLE) && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Status outputs are registered from the next state so they line up with it;
  // the captured word is frozen on the last capture edge and held until the next one.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      bus.load_rdy <= 1'b1;
      bus.scan_en  <= 1'b0;
      bus.cap_vld  <= 1'b0;
      bus.cap_data <= '0;
    end else begin
      bus.load_rdy <= (state_d == IDLE);
      bus.scan_en  <= (state_d != IDLE);
      bus.cap_vld  <= cap_last;
      if (cap_last) begin
        bus.cap_data <= {bus.so, in_q[WIDTH-1:1]};
      end
    end
  end

  // Out-shifter: zeros fill from the top, so sd is naturally 0 in DRAIN and IDLE.
  bw_clk_scan_shreg #(.WIDTH(WIDTH)) u_out_sr (
    .ck        (ck),
    .rst       (rst),
    .load      (accept),
    .load_data (bus.load_data),
    .shift_en  (shift_en),
    .sin       (1'b0),
    .q         (out_q)
  );

  // In-shifter: chain bits enter at the MSB so the first returned bit ends at bit 0.
  bw_clk_scan_shreg #(.WIDTH(WIDTH)) u_in_sr (
    .ck        (ck),
    .rst       (rst),
    .load      (1'b0),
    .load_data ({WIDTH{1'b0}}),
    .shift_en  (cap_en),
    .sin       (bus.so),
    .q         (in_q)
  );

  assign bus.sd = out_q[0];

  // Upper out-shifter bits only feed the shift; in_q[0] is dropped by the final merge with so.
  assign unused_bits = ^{out_q[WIDTH-1:1], in_q[0]};

endmodule

// File: tb/tb_bw_clk_cclk_scan_seq.sv
// Self-checking bench: cycle-level reference model for DLY=1 plus directed DLY=3 loopback.
// Latency: n/a.
// Backpressure: word source holds load_vld until accepted.
module tb_bw_clk_cclk_scan_seq;

  localparam int W    = 16;
  localparam int D    = 1;
  localparam int D3   = 3;
  localparam int MAXC = 8192;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  bw_clk_cclk_scan_seq_if #(.WIDTH(W)) bus ();
  bw_clk_cclk_scan_seq_if #(.WIDTH(W)) bus3 ();

  bw_clk_cclk_scan_seq #(.WIDTH(W), .DLY(D)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  bw_clk_cclk_scan_seq #(.WIDTH(W), .DLY(D3)) dut3 (
    .ck  (ck),
    .rst (rst),
    .bus (bus3)
  );

  // Three-flop loopback chain for the DLY=3 instance.
  logic [D3-1:0] pipe3 = '0;
  always @(posedge ck) pipe3 <= {pipe3[D3-2:0], bus3.sd};
  assign bus3.so = pipe3[D3-1];

  int checks   = 0;
  int failures = 0;

  // Reference model state (DLY=1 instance).
  int             cyc;
  int             e0;
  int             rdy_at;
  logic           m_active;
  logic [W-1:0]   m_word;
  logic [W-1:0]   m_cap;
  logic           drv_vld;
  logic [W-1:0]   drv_data;
  int             so_mode;   // 0 loopback, 1 tie 0, 2 tie 1, 3 random
  logic           sd_hist [MAXC];
  logic           so_hist [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic set_load(input logic v, input logic [W-1:0] d);
    drv_vld       = v;
    drv_data      = d;
    bus.load_vld  = v;
    bus.load_data = d;
  endtask

  // Advance one clock, update the model and compare every output of the DLY=1 instance.
  task automatic step();
    logic prev_rdy;
    logic exp_sd;
    logic exp_en;
    logic exp_cv;
    int   rel;
    prev_rdy = (cyc >= rdy_at);
    @(posedge ck);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (drv_vld && prev_rdy) begin
      e0       = cyc - 1;
      m_word   = drv_data;
      rdy_at   = e0 + W + D + 1;
      m_active = 1'b1;
    end
    rel    = cyc - e0;
    exp_sd = (rel >= 1 && rel <= W) ? m_word[rel-1] : 1'b0;
    exp_en = (rel >= 1 && rel <= W + D);
    exp_cv = m_active && (rel == W + D + 1);
    if (exp_cv) begin
      for (int i = 0; i < W; i++) m_cap[i] = so_hist[e0 + 1 + D + i];
      m_active = 1'b0;
    end
    sd_hist[cyc] = bus.sd;
    case (so_mode)
      0:       bus.so = (cyc >= D) ? sd_hist[cyc - D] : 1'b0;
      1:       bus.so = 1'b0;
      2:       bus.so = 1'b1;
      default: bus.so = 1'($urandom_range(1, 0));
    endcase
    so_hist[cyc] = bus.so;
    check_eq("load_rdy", 32'(bus.load_rdy), 32'(cyc >= rdy_at));
    check_eq("sd", 32'(bus.sd), 32'(exp_sd));
    check_eq("scan_en", 32'(bus.scan_en), 32'(exp_en));
    check_eq("cap_vld", 32'(bus.cap_vld), 32'(exp_cv));
    check_eq("cap_data", 32'(bus.cap_data), 32'(m_cap));
    if (exp_cv && so_mode == 0) check_eq("cap_loop", 32'(bus.cap_data), 32'(m_word));
  endtask

  // Offer one word, then follow it to its capture.
  task automatic run_word(input logic [W-1:0] word, output logic [W-1:0] cap,
                          output int lat, output logic [W-1:0] sdv);
    logic got;
    int   rel;
    for (int n = 0; n < 100 && !(cyc >= rdy_at); n++) step();
    set_load(1'b1, word);
    step();
    set_load(1'b0, word);
    got = 1'b0;
    cap = '0;
    lat = 0;
    sdv = '0;
    for (int k = 0; k < 60 && !got; k++) begin
      rel = cyc - e0;
      if (rel >= 1 && rel <= W) sdv[rel-1] = bus.sd;
      if (bus.cap_vld) begin
        got = 1'b1;
        cap = bus.cap_data;
        lat = rel;
      end else begin
        step();
      end
    end
    check_eq("cap_wait", 32'(got), 32'd1);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_rdy", 32'(bus.load_rdy), 32'd1);
    check_eq("arst_sd", 32'(bus.sd), 32'd0);
    check_eq("arst_en", 32'(bus.scan_en), 32'd0);
    check_eq("arst_cv", 32'(bus.cap_vld), 32'd0);
    check_eq("arst_cap", 32'(bus.cap_data), 32'd0);
    e0       = -1000;
    rdy_at   = 0;
    m_active = 1'b0;
    m_cap    = '0;
    set_load(1'b0, '0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cap;
    logic [W-1:0] sdv;
    int           lat;
    int           e3;
    int           en_cnt;
    int           cv_at;
    int           cv_cnt;
    int           last_acc;
    logic [W-1:0] cap3;

    rst            = 1'b0;
    bus.so         = 1'b0;
    bus3.load_vld  = 1'b0;
    bus3.load_data = '0;
    so_mode        = 0;
    cyc            = 0;
    e0             = -1000;
    rdy_at         = 0;
    m_active       = 1'b0;
    m_word         = '0;
    m_cap          = '0;
    set_load(1'b0, '0);
    sd_hist[0] = 1'b0;
    so_hist[0] = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_eq("rst_rdy", 32'(bus.load_rdy), 32'd1);
    check_eq("rst_sd", 32'(bus.sd), 32'd0);
    check_eq("rst_en", 32'(bus.scan_en), 32'd0);
    check_eq("rst_cv", 32'(bus.cap_vld), 32'd0);
    check_eq("rst_cap", 32'(bus.cap_data), 32'd0);
    check_eq("rst3_rdy", 32'(bus3.load_rdy), 32'd1);
    @(posedge ck);
    #1;
    rst = 1'b0;

    // DLY=3 loopback: single word 0x0001.
    check_eq("d3_rdy", 32'(bus3.load_rdy), 32'd1);
    bus3.load_vld  = 1'b1;
    bus3.load_data = 16'h0001;
    step();
    e3            = cyc - 1;
    bus3.load_vld = 1'b0;
    en_cnt        = 0;
    cv_at         = -1;
    cap3          = '0;
    for (int k = 0; k < 40; k++) begin
      if (bus3.scan_en) en_cnt++;
      if (bus3.cap_vld && cv_at < 0) begin
        cv_at = cyc;
        cap3  = bus3.cap_data;
      end
      step();
    end
    check_eq("d3_lat", 32'(cv_at - e3), 32'd20);
    check_eq("d3_cap", 32'(cap3), 32'h0001);
    check_eq("d3_en_cycles", 32'(en_cnt), 32'd19);

    // DLY=1 loopback, known pattern.
    so_mode = 0;
    run_word(16'hA5C3, cap, lat, sdv);
    check_eq("a5c3_sd_seq", 32'(sdv), 32'hA5C3);
    check_eq("a5c3_lat", 32'(lat), 32'd18);
    check_eq("a5c3_cap", 32'(cap), 32'hA5C3);

    // Chain tied high / low.
    so_mode = 2;
    run_word(W'($urandom), cap, lat, sdv);
    check_eq("tie1_cap", 32'(cap), 32'hFFFF);
    so_mode = 1;
    run_word(W'($urandom), cap, lat, sdv);
    check_eq("tie0_cap", 32'(cap), 32'h0000);

    // load_vld held high with new data every cycle.
    so_mode = 0;
    for (int n = 0; n < 60 && !(cyc >= rdy_at); n++) step();
    last_acc = -1;
    for (int k = 0; k < 80; k++) begin
      set_load(1'b1, W'($urandom));
      if (bus.load_rdy) begin
        if (last_acc >= 0) check_eq("acc_spacing", 32'(cyc - last_acc), 32'd18);
        last_acc = cyc;
      end
      step();
    end
    set_load(1'b0, '0);
    for (int n = 0; n < 60 && (m_active || !(cyc >= rdy_at)); n++) step();

    // Reset in the middle of a shift discards the word.
    set_load(1'b1, 16'hBEEF);
    step();
    set_load(1'b0, '0);
    for (int n = 0; n < 20 && cyc < e0 + 7; n++) step();
    pulse_reset();
    cv_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.cap_vld) cv_cnt++;
      step();
    end
    check_eq("rst_no_cap", 32'(cv_cnt), 32'd0);
    run_word(16'h1234, cap, lat, sdv);
    check_eq("post_rst_cap", 32'(cap), 32'h1234);

    // Randomised traffic under each chain mode.
    for (int blk = 0; blk < 8; blk++) begin
      so_mode = blk % 4;
      for (int k = 0; k < 150; k++) begin
        set_load(($urandom_range(2, 0) == 0), W'($urandom));
        step();
      end
      set_load(1'b0, '0);
      for (int n = 0; n < 60 && (m_active || !(cyc >= rdy_at)); n++) step();
      check_eq("drain_done", 32'(m_active), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bw_clk_cclk_scan_seq.md
# bw_clk_cclk_scan_seq

Scan sequencer that drives the serial scan-data input of a cluster-clock scan-latch chain and collects the chain's serial output. It accepts a parallel word, shifts it LSB-first onto `sd`, samples `so` after a fixed chain delay, and returns the captured word with a one-cycle valid pulse. It sits directly upstream of the cclk scan latches (feeding `sd`) and directly downstream of the chain end (consuming `so`).

## Interface

Parameters:
- `WIDTH`, 16: bits per scan word; legal range is 2 and above.
- `DLY`, 1: ck cycles from `sd` to the same bit on `so`; legal range is 1–8.

Ports (one clock; reset is asynchronous and active-high):
- `ck`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_vld`  in  1  a parallel word is offered.
- `load_data`  in  WIDTH  word to shift out.
- `load_rdy`  out  1  sequencer idle; a load is accepted.
- `sd`  out  1  serial data to the chain's first scan latch.
- `scan_en`  out  1  chain is being shifted.
- `so`  in  1  serial data returned from the chain end.
- `cap_vld`  out  1  single-cycle pulse; `cap_data` is valid.
- `cap_data`  out  WIDTH  captured word, LSB = first bit returned.

## Operation

- FSM has three states: IDLE, SHIFT, DRAIN.
- IDLE:
  - `load_rdy`=1.
  - A load is accepted when `load_vld`&`load_rdy` at an edge: `load_data` goes into the out-shift register, the counter clears, and the FSM moves to SHIFT.
- SHIFT:
  - `sd` = out-shift register bit 0.
  - Each cycle the register shifts right, with 0 filled at the MSB.
  - After WIDTH cycles the FSM moves to DRAIN.
- DRAIN:
  - `sd`=0.
  - The FSM stays DLY cycles, then returns to IDLE.
- Counter: a single up-counter of width clog2(WIDTH+DLY+1), counting cycles since SHIFT entry. It clears on accept and does not wrap.
- Capture:
  - At counter values DLY to DLY+WIDTH-1, `so` is shifted into the in-shift register MSB-first, shifting right.
  - After the last capture edge, bit i holds the i-th returned bit.
- `cap_vld` asserts for exactly the one cycle following the final capture edge. That is the first IDLE cycle; `cap_data` holds until the next capture completes.
- `scan_en`=1 in SHIFT and DRAIN, 0 in IDLE.
- `load_vld` while not in IDLE is ignored. The word is not queued; the source must hold it until `load_rdy`.
- Back-to-back loads:
  - A load may be accepted in the same cycle `cap_vld` is high.
  - `cap_data` from the previous word stays stable during that cycle.
- `so` is don't-care outside capture cycles.

## Timing

- Reset values: FSM in IDLE, `load_rdy`=1, `sd`=0, `scan_en`=0, `cap_vld`=0, `cap_data`=0, counter=0.
- Reset asserted mid-SHIFT or mid-DRAIN:
  - Outputs take their reset values immediately (asynchronous).
  - The partial word is discarded and `cap_vld` never fires for it.
- Accept at edge E0:
  - Bit 0 appears on `sd` in cycle E0+1.
  - Bit i appears in cycle E0+1+i.
- Completion:
  - Latency accept→`cap_vld` is WIDTH+DLY+1 cycles.
  - `load_rdy` returns high in the same cycle `cap_vld` is high.
- Throughput: one word per WIDTH+DLY+1 cycles.
- All outputs are registered; there is no combinational path from `so` or `load_vld` to any output.

## Structure

- Shared package `bw_clk_scan_pkg`:
  - State enum (IDLE, SHIFT, DRAIN).
  - A function computing the counter width from WIDTH and DLY.
- One sub-module is natural: `bw_clk_scan_shreg`, a parameterised shift register with load, shift-enable and serial-in. It is instanced twice: as the out-shifter (load used) and the in-shifter (load tied off).
- Target size is 150–250 lines of RTL in total.

## Test plan

- Loopback, WIDTH=16, DLY=1, `so`=`sd` delayed one flop: load 16'hA5C3 → `sd` shows 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 in cycles E0+1..E0+16; `cap_vld` pulses at E0+18 with `cap_data`=16'hA5C3.
- DLY=3 loopback model: load 16'h0001 → `cap_vld` at E0+20, `cap_data`=16'h0001; `scan_en` is high for exactly 19 cycles.
- `so` tied 1, any load → `cap_data`=16'hFFFF; `so` tied 0 → 16'h0000.
- `load_vld` held high with changing data:
  - A second word offered during SHIFT is ignored.
  - Loads are accepted only on `load_rdy` cycles, spaced 18 cycles apart for DLY=1.
  - Each `cap_data` matches the word accepted.
- Assert `rst` at E0+7 for one cycle → all outputs return to reset values at once and no `cap_vld` follows; a fresh load of 16'h1234 afterwards captures 16'h1234.
